fixedpoint_cmult_pipe: RTL and testbench

FIXEDPOINT_CMULT_PIPE -- requirements
Module: fixedpoint_cmult_pipe

---
 rtl/fixedpoint_cmult_pipe.sv | 106 ++++++++++
 tb/tb_fixedpoint_cmult_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fixedpoint_cmult_pipe.sv
// Per-lane signed multiply by programmable coefficients, two-stage pipeline with ready/valid.
// Define FIXEDPOINT_CMULT_SATURATE_EN to clamp overflowing lanes instead of wrapping them.
module fixedpoint_cmult_pipe #(
   parameter int IN_W    = 32,
   parameter int CONST_W = 24,
   parameter int FRAC    = 15,
   parameter int OUT_W   = 32,
   parameter int LANES   = 8,
   localparam int CIW    = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     coef_we,
   input  logic [CIW-1:0]           coef_idx,
   input  logic [CONST_W-1:0]       coef_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*IN_W-1:0]    in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*OUT_W-1:0]   out_data,
   output logic [LANES-1:0]         out_sat
);

   localparam int PW = IN_W + CONST_W;
   localparam int RW = PW + 1 - FRAC;
   localparam int EW = ((RW > OUT_W) ? RW : OUT_W) + 1;
   localparam logic signed [PW:0] HALF = (PW + 1)'(1) <<< (FRAC - 1);
   localparam logic signed [CONST_W-1:0] UNITY = CONST_W'(1) <<< FRAC;

   logic                        en;
   logic                        s1_valid;
   logic signed [PW-1:0]        s1_prod [LANES];
   logic signed [CONST_W-1:0]   coef [LANES];
   logic [LANES*OUT_W-1:0]      res_data;
   logic [LANES-1:0]            res_sat;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic signed [PW:0]      wide;
      logic signed [EW-1:0]    scaled;
      logic [OUT_W-1:0]        lane_data;
      logic                    lane_sat;

      // Bias by half an LSB then floor-shift: rounds half toward +infinity.
      assign wide   = $signed({s1_prod[k][PW-1], s1_prod[k]}) + HALF;
      assign scaled = EW'(wide >>> FRAC);

`ifdef FIXEDPOINT_CMULT_SATURATE_EN
      localparam logic signed [EW-1:0] MAXV = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [EW-1:0] MINV = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

      always_comb begin
         lane_data = OUT_W'(scaled);
         lane_sat  = 1'b0;
         if (scaled > MAXV) begin
            lane_data = MAXV[OUT_W-1:0];
            lane_sat  = 1'b1;
         end else if (scaled < MINV) begin
            lane_data = MINV[OUT_W-1:0];
            lane_sat  = 1'b1;
         end
      end
`else
      assign lane_data = OUT_W'(scaled);
      assign lane_sat  = 1'b0;
`endif

      assign res_data[k*OUT_W +: OUT_W] = lane_data;
      assign res_sat[k]                 = lane_sat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= '0;
         for (int k = 0; k < LANES; k++) begin
            coef[k]    <= UNITY;
            s1_prod[k] <= '0;
         end
      end else begin
         // Coefficient writes land regardless of stall; the capture below still sees the old value.
         if (coef_we && (int'(coef_idx) < LANES)) begin
            coef[coef_idx] <= coef_data;
         end
         if (en) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (in_valid) begin
               for (int k = 0; k < LANES; k++) begin
                  s1_prod[k] <= PW'($signed(in_data[k*IN_W +: IN_W])) * PW'(coef[k]);
               end
            end
            if (s1_valid) begin
               out_data <= res_data;
               out_sat  <= res_sat;
            end
         end
      end
   end

endmodule

// File: tb/tb_fixedpoint_cmult_pipe.sv
// Directed + randomized bench for fixedpoint_cmult_pipe with a reference-model scoreboard.
module tb_fixedpoint_cmult_pipe;

   localparam int IN_W    = 32;
   localparam int CONST_W = 24;
   localparam int FRAC    = 15;
   localparam int OUT_W   = 32;
   localparam int LANES   = 8;
   localparam int CIW     = 3;

   typedef struct packed {
      logic [LANES*OUT_W-1:0] d;
      logic [LANES-1:0]       s;
   } beat_t;

   logic                     clk;
   logic                     rst;
   logic                     coef_we;
   logic [CIW-1:0]           coef_idx;
   logic [CONST_W-1:0]       coef_data;
   logic                     in_valid;
   logic                     in_ready;
   logic [LANES*IN_W-1:0]    in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [LANES*OUT_W-1:0]   out_data;
   logic [LANES-1:0]         out_sat;

   int n_pass  = 0;
   int n_total = 0;

   beat_t                     sb[$];
   logic signed [CONST_W-1:0] mcoef [LANES];

   fixedpoint_cmult_pipe #(
      .IN_W(IN_W), .CONST_W(CONST_W), .FRAC(FRAC), .OUT_W(OUT_W), .LANES(LANES)
   ) dut (
      .clk(clk), .rst(rst),
      .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sat(out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic beat_t model(input logic [LANES*IN_W-1:0] din);
      beat_t  b;
      longint x, p, r;
      b = '0;
      for (int k = 0; k < LANES; k++) begin
         x = $signed(din[k*IN_W +: IN_W]);
         p = x * longint'(mcoef[k]);
         r = (p + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
`ifdef FIXEDPOINT_CMULT_SATURATE_EN
         if (r > 64'sh7FFF_FFFF) begin
            b.d[k*OUT_W +: OUT_W] = 32'h7FFF_FFFF;
            b.s[k] = 1'b1;
         end else if (r < -64'sh8000_0000) begin
            b.d[k*OUT_W +: OUT_W] = 32'h8000_0000;
            b.s[k] = 1'b1;
         end else begin
            b.d[k*OUT_W +: OUT_W] = r[OUT_W-1:0];
         end
`else
         b.d[k*OUT_W +: OUT_W] = r[OUT_W-1:0];
`endif
      end
      return b;
   endfunction

   // Reference model: captures expectations on acceptance using pre-write coefficients.
   always @(posedge clk) begin
      if (rst) begin
         sb.delete();
         for (int k = 0; k < LANES; k++) mcoef[k] = CONST_W'(1) <<< FRAC;
      end else begin
         if (in_valid && in_ready) sb.push_back(model(in_data));
         if (coef_we && (int'(coef_idx) < LANES)) mcoef[coef_idx] = coef_data;
      end
   end

   always @(negedge clk) begin
      beat_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_beat", 256'(out_valid), 256'(0));
         end else begin
            e = sb.pop_front();
            check("out_data", 256'(out_data), 256'(e.d));
            check("out_sat", 256'(out_sat), 256'(e.s));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_data();
      for (int k = 0; k < LANES; k++) in_data[k*IN_W +: IN_W] = $urandom;
   endtask

   task automatic wr_coef(input int idx, input logic [CONST_W-1:0] val);
      coef_we   = 1'b1;
      coef_idx  = CIW'(idx);
      coef_data = val;
      step();
      coef_we   = 1'b0;
   endtask

   initial begin
      rst = 1'b1; coef_we = 1'b1; coef_idx = '0; coef_data = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (3) step();
      check("rst_out_valid", 256'(out_valid), 256'(0));
      check("rst_out_data", 256'(out_data), 256'(0));
      check("rst_out_sat", 256'(out_sat), 256'(0));

      rst = 1'b0; coef_we = 1'b0;
      #1;
      check("in_ready_after_rst", 256'(in_ready), 256'(1));

      // Unity gain after reset; coefficient write during reset must not have landed.
      rand_data();
      in_data[31:0] = 32'd100;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("lat_cycle1_valid", 256'(out_valid), 256'(0));
      step();
      check("lat_cycle2_valid", 256'(out_valid), 256'(1));
      check("unity_lane0", 256'(out_data[31:0]), 256'(100));
      check("unity_sat", 256'(out_sat), 256'(0));
      step();

      // Half gain, back-to-back beats, rounding toward +inf.
      wr_coef(0, 24'h004000);
      rand_data(); in_data[31:0] = 32'd3; in_valid = 1'b1;
      step();
      rand_data(); in_data[31:0] = -32'sd3;
      step();
      in_valid = 1'b0;
      check("half_pos_valid", 256'(out_valid), 256'(1));
      check("half_pos", 256'(out_data[31:0]), 256'(32'd2));
      step();
      check("half_neg_valid", 256'(out_valid), 256'(1));
      check("half_neg", 256'(out_data[31:0]), 256'(32'hFFFF_FFFF));
      step();

      // Overflow on lanes 0 and 1 with gain 2.0.
      wr_coef(0, 24'h010000);
      wr_coef(1, 24'h010000);
      rand_data();
      in_data[31:0]  = 32'h7FFF_FFFF;
      in_data[63:32] = 32'h8000_0000;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
`ifdef FIXEDPOINT_CMULT_SATURATE_EN
      check("ovf_lane0", 256'(out_data[31:0]), 256'(32'h7FFF_FFFF));
      check("ovf_lane1", 256'(out_data[63:32]), 256'(32'h8000_0000));
      check("ovf_sat", 256'(out_sat[1:0]), 256'(2'b11));
`else
      check("ovf_lane0", 256'(out_data[31:0]), 256'(32'hFFFF_FFFE));
      check("ovf_lane1", 256'(out_data[63:32]), 256'(32'h0000_0000));
      check("ovf_sat", 256'(out_sat[1:0]), 256'(2'b00));
`endif
      step();

      // Backpressure: three beats with out_ready low for five cycles.
      out_ready = 1'b0;
      rand_data(); in_valid = 1'b1;
      step();
      rand_data();
      step();
      rand_data();
      for (int i = 0; i < 3; i++) begin
         check("bp_out_valid", 256'(out_valid), 256'(1));
         check("bp_in_ready", 256'(in_ready), 256'(0));
         step();
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 256'(in_ready), 256'(1));
      step();
      in_valid = 1'b0;
      repeat (4) step();
      check("bp_drained", 256'(sb.size()), 256'(0));

      // Coefficient write coincident with acceptance uses the old coefficient.
      wr_coef(2, 24'h008000);
      rand_data(); in_data[95:64] = 32'd1000; in_valid = 1'b1;
      coef_we = 1'b1; coef_idx = 3'd2; coef_data = 24'h004000;
      step();
      coef_we = 1'b0;
      rand_data(); in_data[95:64] = 32'd1000;
      step();
      in_valid = 1'b0;
      check("coef_old_lane2", 256'(out_data[95:64]), 256'(1000));
      step();
      check("coef_new_lane2", 256'(out_data[95:64]), 256'(500));
      step();

      // Reset with two beats in flight.
      wr_coef(0, 24'h004000);
      out_ready = 1'b0;
      rand_data(); in_data[31:0] = 32'd9; in_valid = 1'b1;
      step();
      rand_data(); in_data[31:0] = 32'd11;
      step();
      in_valid = 1'b0; rst = 1'b1;
      step();
      check("midrst_out_valid", 256'(out_valid), 256'(0));
      rst = 1'b0; out_ready = 1'b1;
      #1;
      check("midrst_in_ready", 256'(in_ready), 256'(1));
      rand_data(); in_data[31:0] = 32'd7; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      check("midrst_unity", 256'(out_data[31:0]), 256'(7));
      step();

      // Random traffic with random stalls and coefficient writes.
      for (int i = 0; i < 60; i++) begin
         rand_data();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         coef_we   = ($urandom_range(0, 4) == 0);
         coef_idx  = CIW'($urandom_range(0, LANES - 1));
         coef_data = CONST_W'($urandom);
         step();
      end
      in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 20 && sb.size() > 0; i++) step();
      check("final_drained", 256'(sb.size()), 256'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
